dbus_uart_tx: RTL and testbench
===============================

# dbus_uart_tx

Memory-mapped UART transmitter that sits as a responder on the processor data bus (Dw* signals), decoding a 16-byte window and accepting stores and loads in the same single-cycle fashion as data memory. Bytes stored to its data register enter an 8-entry FIFO. A divider-paced shifter drains the FIFO onto a serial line as 8N1 frames, LSB first. Status is readable by software, so programs can poll before writing.

## Interface
- BASE_ADDR, 32'hFF200100: window base; bits [3:0] ignored.
- DIVISOR, 16'd434: reset value of the baud divider, in clocks per bit (50 MHz / 115200).
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, at most 16.

Ports (direction, width, meaning):
- iCLK, in, 1: system clock.
- iRST_N, in, 1: asynchronous active-low reset.
- iDwReadEnable, in, 1: bus load strobe.
- iDwWriteEnable, in, 1: bus store strobe.
- iDwByteEnable, in, 4: byte lanes of the store.
- iDwAddress, in, 32: bus address.
- iDwWriteData, in, 32: store data.
- oDwReadData, out, 32: load data; 0 when not selected (OR-able onto the bus).
- oTX, out, 1: serial output; idles high.
- oIRQ, out, 1: present only with UART_TX_IRQ_EN.

## Operation
- Select: iDwAddress[31:4] == BASE_ADDR[31:4]. Register offset is iDwAddress[3:2].
- Offset 0x0, TXDATA:
  - A store with iDwByteEnable[0]=1 pushes iDwWriteData[7:0].
  - Reads 0.
- Offset 0x4, STATUS:
  - bit0 busy (state ≠ IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bit4 irq_en; bits[12:8] count. All other bits 0.
  - Store with BE[0]: writing 1 to bit3 clears overflow; bit4 written directly.
- Offset 0x8, DIV:
  - bits[15:0] R/W. BE[0] updates bits [7:0]; BE[1] updates bits [15:8].
  - A stored value below 2 is clamped to 2.
- Offset 0xC: reads 0; writes ignored.
- Push while full is dropped and sets overflow. Exception: a push and a pop in the same cycle while full is accepted, and count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when FIFO non-empty. Pops the head into the shift register and loads the baud counter with DIV−1.
  - Each state holds for DIV cycles. The counter counts down, and the bit ends at 0.
  - START drives 0.
  - DATA drives shift[0], shifts right each bit, and runs 8 bits (bit index 0..7) before going to STOP.
  - STOP drives 1. At its end: pop and go to START if non-empty, else go to IDLE.
- A DIV write mid-frame takes effect at the next bit-boundary reload.
- Reset values: oTX=1, state IDLE, FIFO empty (pointers 0), DIV=DIVISOR, overflow=0, irq_en=0, oIRQ=0.
- Reset is asserted asynchronously mid-frame: oTX returns high immediately and FIFO contents are discarded.

## Timing
- Stores commit on the iCLK rising edge with iDwWriteEnable=1. Results are visible in STATUS from the following cycle.
- Loads are combinational from the current address and registers, with zero wait states.
- Latency: a push at edge N into an idle, empty block makes oTX fall at edge N+1.
- Frame length is exactly 10×DIV cycles. Back-to-back frames have no idle gap.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- oTX and oIRQ are registered outputs, with no combinational path from the bus.

## Configuration
- UART_TX_IRQ_EN defined:
  - oIRQ port exists.
  - oIRQ is registered: irq_en & empty & ~busy.
  - STATUS bit4 is functional.
- UART_TX_IRQ_EN undefined:
  - No oIRQ port.
  - STATUS bit4 reads 0 and writes are ignored.
  - All other behaviour is identical.

## Test plan
- Reset checks, with iRST_N low then high:
  - oTX=1.
  - A load of BASE+4 returns 32'h00000004 (empty only).
  - A load of BASE+8 returns 434.
- Single frame:
  - Set DIV=4.
  - Store 8'hA5 to BASE+0 at edge N.
  - Expect oTX low from edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high.
  - Expect busy to clear 40 cycles after N+1.
- Back-to-back and full:
  - With DIV=4, push 9 bytes in consecutive cycles.
  - Expect the first byte popped at once.
  - Expect count to reach 8 with full=1 and overflow=0.
  - Expect 9 contiguous frames with no idle gap.
  - Then push 9 more rapidly: expect overflow=1 and dropped bytes never transmitted.
  - A store of 32'h8 to BASE+4 clears overflow.
- Decode and lanes:
  - A store to BASE+0 with BE=4'b0010 pushes nothing.
  - A store to BASE+0x10 has no effect.
  - A load from outside the window returns 0.
  - DIV=1 is written → reads back 2.
- Reset mid-frame:
  - Pull iRST_N low during a DATA bit.
  - Expect oTX=1 immediately, STATUS=4 after release, and no frame resumes.
- IRQ (UART_TX_IRQ_EN):
  - With irq_en=1 set: oIRQ=1 while idle.
  - A push drops oIRQ the next cycle.
  - oIRQ re-asserts one cycle after the last STOP ends.

Source files
------------

// File: rtl/dbus_uart_tx_if.sv
// Processor data-bus (Dw*) signals seen by a memory-mapped responder.
// Signal names follow the bus naming used by the core.
interface dbus_uart_tx_if;
    logic        iDwReadEnable;
    logic        iDwWriteEnable;
    logic [3:0]  iDwByteEnable;
    logic [31:0] iDwAddress;
    logic [31:0] iDwWriteData;
    logic [31:0] oDwReadData;

    modport master (
        output iDwReadEnable, iDwWriteEnable, iDwByteEnable, iDwAddress, iDwWriteData,
        input  oDwReadData
    );

    modport slave (
        input  iDwReadEnable, iDwWriteEnable, iDwByteEnable, iDwAddress, iDwWriteData,
        output oDwReadData
    );
endinterface

// File: rtl/dbus_uart_tx.sv
// Data-bus mapped UART transmitter: 16-byte register window, TX FIFO, 8N1 LSB-first shifter.
// Define UART_TX_IRQ_EN to add the oIRQ output and a functional STATUS.irq_en bit.
module dbus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFF20_0100,
    parameter logic [15:0] DIVISOR    = 16'd434,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    dbus_uart_tx_if.slave bus,
    output logic          oTX
`ifdef UART_TX_IRQ_EN
    ,
    output logic          oIRQ
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;

    logic          sel, wr, be0, full, empty, busy, bit_end, push_req, push, pop;
    logic [1:0]    off;
    logic [31:0]   wdata;
    logic [15:0]   div_new;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel      = bus.iDwAddress[31:4] == BASE_ADDR[31:4];
    assign off      = bus.iDwAddress[3:2];
    assign wr       = sel & bus.iDwWriteEnable;
    assign be0      = bus.iDwByteEnable[0];
    assign wdata    = bus.iDwWriteData;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign busy     = state_q != StIdle;
    assign bit_end  = cnt_q == '0;
    assign push_req = wr & (off == 2'd0) & be0;
    assign pop      = ~empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push     = push_req & (~full | pop);
    assign status   = {19'b0, 5'(count_q), 3'b0, irq_en_q, ovf_q, empty, full, busy};

    assign unused_bits = ^{wdata[31:16], wdata[4], bus.iDwAddress[1:0], bus.iDwByteEnable[3:2]};

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            mem_d[wptr_q] = wdata[7:0];
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        ovf_d = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (wr && off == 2'd1 && be0 && wdata[3]) begin
            ovf_d = 1'b0;
        end

        div_new = div_q;
        if (bus.iDwByteEnable[0]) div_new[7:0] = wdata[7:0];
        if (bus.iDwByteEnable[1]) div_new[15:8] = wdata[15:8];
        div_d = div_q;
        if (wr && off == 2'd2) begin
            div_d = (div_new < 16'd2) ? 16'd2 : div_new;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q, irq_d;
    assign irq_en_d = (wr && off == 2'd1 && be0) ? wdata[4] : irq_en_q;
    assign irq_d    = irq_en_q & empty & ~busy;
    assign oIRQ     = irq_q;
`else
    assign irq_en_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q == StIdle) begin
            if (!empty) begin
                state_d = StStart;
                tx_d    = 1'b0;
                cnt_d   = div_q - 16'd1;
                shift_d = mem_q[rptr_q];
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            // Each bit boundary reloads from the live divider register.
            cnt_d = div_q - 16'd1;
            case (state_q)
                StStart: begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                end
                StData: begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
                default: begin
                    if (!empty) begin
                        state_d = StStart;
                        tx_d    = 1'b0;
                        shift_d = mem_q[rptr_q];
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.oDwReadData = '0;
        if (sel && bus.iDwReadEnable) begin
            case (off)
                2'd1:    bus.oDwReadData = status;
                2'd2:    bus.oDwReadData = {16'b0, div_q};
                default: bus.oDwReadData = '0;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            div_q    <= DIVISOR;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
`ifdef UART_TX_IRQ_EN
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
`ifdef UART_TX_IRQ_EN
            irq_q    <= irq_d;
`endif
        end
    end

    assign oTX = tx_q;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Self-checking bench for dbus_uart_tx: frame-level model of the FIFO and serial line,
// compared against oTX (and oIRQ) every cycle, plus directed literal register checks.
module tb_dbus_uart_tx;
    localparam logic [31:0] BASE  = 32'hFF20_0100;
    localparam int          DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif

    dbus_uart_tx_if bus ();

    dbus_uart_tx #(
        .BASE_ADDR (BASE),
        .DIVISOR   (16'd434),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus),
        .oTX   (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .oIRQ  (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending bytes, and the frame in flight as (byte, start cycle, divider).
    byte unsigned mq[$];
    bit           m_busy   = 0;
    int           m_start  = 0;
    int           m_div_f  = 4;
    logic [7:0]   m_byte   = '0;
    logic [15:0]  m_div    = 16'd434;
    bit           m_ovf    = 0;
    bit           m_irq_en = 0;
    bit           m_irq    = 0;
    int           cyc      = 0;

    task automatic model_step();
        bit          irq_next;
        logic [15:0] nd;
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_div = 16'd434; m_ovf = 0; m_irq_en = 0; m_irq = 0;
            return;
        end
        cyc++;
        irq_next = m_irq_en && (mq.size() == 0) && !m_busy;
        if (m_busy && (cyc - m_start) == 10 * m_div_f) m_busy = 0;
        if (!m_busy && mq.size() > 0) begin
            m_byte  = mq.pop_front();
            m_start = cyc;
            m_div_f = int'(m_div);
            m_busy  = 1;
        end
        if (bus.iDwWriteEnable && bus.iDwAddress[31:4] == BASE[31:4]) begin
            case (bus.iDwAddress[3:2])
                2'd0: if (bus.iDwByteEnable[0]) begin
                    if (mq.size() < DEPTH) mq.push_back(bus.iDwWriteData[7:0]);
                    else m_ovf = 1;
                end
                2'd1: if (bus.iDwByteEnable[0]) begin
                    if (bus.iDwWriteData[3]) m_ovf = 0;
`ifdef UART_TX_IRQ_EN
                    m_irq_en = bus.iDwWriteData[4];
`endif
                end
                2'd2: begin
                    nd = m_div;
                    if (bus.iDwByteEnable[0]) nd[7:0] = bus.iDwWriteData[7:0];
                    if (bus.iDwByteEnable[1]) nd[15:8] = bus.iDwWriteData[15:8];
                    m_div = (nd < 16'd2) ? 16'd2 : nd;
                end
                default: ;
            endcase
        end
        m_irq = irq_next;
    endtask

    function automatic logic tx_exp();
        int k;
        if (!m_busy) return 1'b1;
        k = (cyc - m_start) / m_div_f;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s       = '0;
        s[0]    = m_busy;
        s[1]    = mq.size() == DEPTH;
        s[2]    = mq.size() == 0;
        s[3]    = m_ovf;
        s[4]    = m_irq_en;
        s[12:8] = 5'(mq.size());
        return s;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("tx_vs_model", 32'(tx), 32'(tx_exp()));
`ifdef UART_TX_IRQ_EN
            chk("irq_vs_model", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.iDwAddress     = a;
        bus.iDwWriteData   = d;
        bus.iDwByteEnable  = be;
        bus.iDwWriteEnable = 1'b1;
        @(posedge clk);
        #1;
        bus.iDwWriteEnable = 1'b0;
        bus.iDwByteEnable  = 4'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.iDwAddress    = a;
        bus.iDwReadEnable = 1'b1;
        #1;
        d = bus.oDwReadData;
        bus.iDwReadEnable = 1'b0;
    endtask

    task automatic chk_status(input string name, input logic [31:0] lit);
        logic [31:0] d;
        rd(BASE + 32'h4, d);
        chk(name, d, lit);
        chk({name, "_model"}, d, status_exp());
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] lit);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, lit);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    logic [9:0] pat;
    logic [7:0] burst [9];
    int         n0;

    initial begin
        bus.iDwReadEnable  = 1'b0;
        bus.iDwWriteEnable = 1'b0;
        bus.iDwByteEnable  = 4'b0;
        bus.iDwAddress     = '0;
        bus.iDwWriteData   = '0;
        burst = '{8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A, 8'h96, 8'h01, 8'h80, 8'hC3};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("tx_in_reset", 32'(tx), 32'h1);
        rst_n = 1'b1;
        step(1);
        chk("rst_tx", 32'(tx), 32'h1);
        chk_status("rst_status", 32'h4);
        chk_reg("rst_div", BASE + 32'h8, 32'd434);

        // Single frame, DIV=4
        wr(BASE + 32'h8, 32'h4, 4'b0011);
        chk_reg("div4", BASE + 32'h8, 32'd4);
        wr(BASE, 32'hA5, 4'b0001);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (i % 4 == 1) chk("a5_bit", 32'(tx), 32'(pat[i/4]));
        end
        chk_status("a5_busy_last", 32'h5);
        step(1);
        chk_status("a5_idle", 32'h4);
        chk("a5_tx_idle", 32'(tx), 32'h1);

        // Back-to-back, full, overflow, push+pop while full
        wr(BASE, 32'(burst[0]), 4'b0001);
        n0 = cyc;
        chk_status("b2b_first_push", 32'h100);
        wr(BASE, 32'(burst[1]), 4'b0001);
        chk_status("b2b_popped_at_once", 32'h101);
        for (int i = 2; i < 9; i++) wr(BASE, 32'(burst[i]), 4'b0001);
        chk_status("b2b_full", 32'h803);
        for (int i = 0; i < 9; i++) wr(BASE, 32'hEE, 4'b0001);
        chk_status("b2b_overflow", 32'h80B);
        wr(BASE + 32'h4, 32'h8, 4'b0001);
        chk_status("b2b_ovf_clear", 32'h803);
        for (int i = 0; i < 100 && cyc < n0 + 40; i++) step(1);
        chk("b2b_sync", cyc, n0 + 40);
        wr(BASE, 32'h77, 4'b0001);
        chk_status("full_push_pop", 32'h803);
        step(400);
        chk_status("b2b_drained", 32'h4);

        // Decode and lanes
        wr(BASE, 32'h55, 4'b0010);
        chk_status("lane1_no_push", 32'h4);
        wr(BASE + 32'h10, 32'h55, 4'b0001);
        wr(BASE + 32'h18, 32'h9, 4'b1111);
        chk_status("outside_no_push", 32'h4);
        chk_reg("outside_no_div", BASE + 32'h8, 32'd4);
        chk_reg("outside_read", BASE + 32'h10, 32'h0);
        chk_reg("off_c_read", BASE + 32'hC, 32'h0);
        chk_reg("txdata_read", BASE, 32'h0);
        wr(BASE + 32'h8, 32'h1, 4'b0011);
        chk_reg("div_clamp", BASE + 32'h8, 32'd2);
        wr(BASE + 32'h8, 32'h0000_0300, 4'b0010);
        chk_reg("div_hi_lane", BASE + 32'h8, 32'h302);
        wr(BASE + 32'h8, 32'h4, 4'b0011);
        step(10);

        // Reset mid-frame
        wr(BASE, 32'h00, 4'b0001);
        wr(BASE, 32'h00, 4'b0001);
        wr(BASE, 32'h42, 4'b0001);
        step(6);
        chk("midframe_data0", 32'(tx), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx), 32'h1);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk_status("post_reset_status", 32'h4);
        chk_reg("post_reset_div", BASE + 32'h8, 32'd434);
        step(60);
        chk("no_resume", 32'(tx), 32'h1);

        // Interrupt
        wr(BASE + 32'h8, 32'h4, 4'b0011);
`ifdef UART_TX_IRQ_EN
        wr(BASE + 32'h4, 32'h10, 4'b0001);
        chk("irq_not_yet", 32'(irq), 32'h0);
        step(1);
        chk("irq_idle", 32'(irq), 32'h1);
        chk_status("irq_en_status", 32'h14);
        wr(BASE, 32'h3C, 4'b0001);
        chk("irq_push_edge", 32'(irq), 32'h1);
        step(1);
        chk("irq_drop", 32'(irq), 32'h0);
        step(39);
        chk("irq_frame", 32'(irq), 32'h0);
        step(1);
        chk("irq_stop_end", 32'(irq), 32'h0);
        step(1);
        chk("irq_reassert", 32'(irq), 32'h1);
`else
        wr(BASE + 32'h4, 32'h10, 4'b0001);
        chk_status("irq_en_absent", 32'h4);
`endif
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
